// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds FSM states, grant encoding and latency counter width.
package mem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      GNT_IF,
      GNT_D
   } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters.
// One transaction in flight; data wins unless it won last time.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_LATENCY   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req,
   input  logic [ADDRESS_WIDTH-1:0] if_addr,
   output logic                     if_ack,
   output logic [DATA_WIDTH-1:0]    if_rdata,
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [ADDRESS_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0]    d_wdata,
   output logic                     d_ack,
   output logic [DATA_WIDTH-1:0]    d_rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     stall_if,
   output logic                     stall_mem
);

   arb_state_t               state_q, state_d;
   gnt_t                     gnt_q, gnt_d;
   logic [CNT_W-1:0]         cnt_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [DATA_WIDTH-1:0]    rdata_q;
   logic                     we_q;
   logic                     pick_d;
   logic                     grant;
   logic                     last_wait;

   // Fetch only overtakes data when data was granted last time.
   assign pick_d    = d_req & ~(if_req & (gnt_q == GNT_D));
   assign grant     = (state_q == IDLE) & (if_req | d_req);
   assign last_wait = (state_q == WAIT) & (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ISSUE;
               gnt_d   = pick_d ? GNT_D : GNT_IF;
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    if (last_wait) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt_q   <= GNT_IF;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         gnt_q <= gnt_d;
         if (grant) begin
            addr_q  <= pick_d ? d_addr : if_addr;
            we_q    <= pick_d & d_we;
            wdata_q <= pick_d ? d_wdata : wdata_q;
         end
         if (state_q == ISSUE) cnt_q <= CNT_W'(MEM_LATENCY);
         if (state_q == WAIT)  cnt_q <= cnt_q - 1'b1;
         if (last_wait)        rdata_q <= mem_rdata;
      end
   end

   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = (state_q == ISSUE) & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign if_ack    = (state_q == RESP) & (gnt_q == GNT_IF);
   assign d_ack     = (state_q == RESP) & (gnt_q == GNT_D);
   assign if_rdata  = rdata_q;
   assign d_rdata   = rdata_q;

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=2.
// Memory model returns {addr[15:0],16'hA5A5} two cycles after mem_en.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ack;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_if, stall_mem;
   logic [31:0] a1, a2;

   int cmp = 0;
   int mism = 0;

   logic        en_a[40], we_a[40], ia_a[40], da_a[40], si_a[40], sm_a[40];
   logic [31:0] ad_a[40], wd_a[40], ird_a[40], drd_a[40];

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always @(posedge clk) begin
      a1 <= mem_addr;
      a2 <= a1;
   end
   assign mem_rdata = {a2[15:0], 16'hA5A5};

   // Runs n cycles from the current negedge, recording outputs per cycle.
   task automatic run(input int n, input int drop_if, input bit hold);
      for (int c = 0; c < n; c++) begin
         if (c == drop_if) if_req = 1'b0;
         #1;
         en_a[c] = mem_en;  we_a[c] = mem_we;
         ad_a[c] = mem_addr; wd_a[c] = mem_wdata;
         ia_a[c] = if_ack;  da_a[c] = d_ack;
         ird_a[c] = if_rdata; drd_a[c] = d_rdata;
         si_a[c] = stall_if; sm_a[c] = stall_mem;
         if (!hold) begin
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      @(negedge clk); @(negedge clk); #1;
      cmp++; if (if_ack !== 1'b0) begin mism++; $display("FAIL rst_if_ack got %b want 0", if_ack); end
      cmp++; if (d_ack !== 1'b0) begin mism++; $display("FAIL rst_d_ack got %b want 0", d_ack); end
      cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin mism++; $display("FAIL rst_mem_en_we got %b%b want 00", mem_en, mem_we); end
      cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin mism++; $display("FAIL rst_mem_addr_wdata got %h %h want 0 0", mem_addr, mem_wdata); end
      cmp++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin mism++; $display("FAIL rst_rdata got %h %h want 0 0", if_rdata, d_rdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      int n_en = 0, n_ack = 0;
      if_req = 1; if_addr = 32'h10;
      run(8, -1, 0);
      for (int c = 0; c < 8; c++) begin
         n_en += int'(en_a[c]);
         n_ack += int'(ia_a[c]) + int'(da_a[c]);
      end
      cmp++; if (en_a[1] !== 1'b1 || ad_a[1] !== 32'h10) begin mism++; $display("FAIL fetch_issue got en=%b addr=%h want 1 00000010", en_a[1], ad_a[1]); end
      cmp++; if (n_en != 1) begin mism++; $display("FAIL fetch_en_count got %0d want 1", n_en); end
      cmp++; if (ia_a[4] !== 1'b1 || ird_a[4] !== 32'h0010A5A5) begin mism++; $display("FAIL fetch_ack got ack=%b data=%h want 1 0010a5a5", ia_a[4], ird_a[4]); end
      cmp++; if (n_ack != 1) begin mism++; $display("FAIL fetch_ack_count got %0d want 1", n_ack); end
      cmp++; if (si_a[0] !== 1'b1 || si_a[4] !== 1'b0) begin mism++; $display("FAIL fetch_stall got %b%b want 10", si_a[0], si_a[4]); end
   endtask

   task automatic test_both();
      if_req = 1; if_addr = 32'h20;
      d_req = 1; d_we = 0; d_addr = 32'h40;
      run(12, -1, 0);
      cmp++; if (ad_a[1] !== 32'h40 || we_a[1] !== 1'b0) begin mism++; $display("FAIL both_first_issue got addr=%h we=%b want 00000040 0", ad_a[1], we_a[1]); end
      cmp++; if (da_a[4] !== 1'b1 || drd_a[4] !== 32'h0040A5A5) begin mism++; $display("FAIL both_d_ack got ack=%b data=%h want 1 0040a5a5", da_a[4], drd_a[4]); end
      cmp++; if (ia_a[4] !== 1'b0) begin mism++; $display("FAIL both_ack_overlap got if_ack=%b want 0", ia_a[4]); end
      cmp++; if (en_a[6] !== 1'b1 || ad_a[6] !== 32'h20 || en_a[5] !== 1'b0) begin mism++; $display("FAIL both_fetch_issue got en6=%b addr=%h en5=%b want 1 00000020 0", en_a[6], ad_a[6], en_a[5]); end
      cmp++; if (ia_a[9] !== 1'b1 || ird_a[9] !== 32'h0020A5A5) begin mism++; $display("FAIL both_if_ack got ack=%b data=%h want 1 0020a5a5", ia_a[9], ird_a[9]); end
   endtask

   task automatic test_store();
      int n_we = 0;
      d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
      run(8, -1, 0);
      d_we = 0;
      for (int c = 0; c < 8; c++) n_we += int'(we_a[c]);
      cmp++; if (we_a[1] !== 1'b1 || n_we != 1) begin mism++; $display("FAIL store_we got we1=%b count=%0d want 1 1", we_a[1], n_we); end
      cmp++; if (ad_a[1] !== 32'h80 || wd_a[1] !== 32'hDEADBEEF) begin mism++; $display("FAIL store_issue got %h %h want 00000080 deadbeef", ad_a[1], wd_a[1]); end
      cmp++; if (da_a[4] !== 1'b1 || da_a[3] !== 1'b0) begin mism++; $display("FAIL store_ack got c3=%b c4=%b want 0 1", da_a[3], da_a[4]); end
      cmp++; if ({sm_a[0], sm_a[1], sm_a[2], sm_a[3], sm_a[4]} !== 5'b11110) begin mism++; $display("FAIL store_stall got %b%b%b%b%b want 11110", sm_a[0], sm_a[1], sm_a[2], sm_a[3], sm_a[4]); end
   endtask

   task automatic test_drop();
      int n_en = 0;
      if_req = 1; if_addr = 32'h30;
      run(10, 2, 0);
      for (int c = 0; c < 10; c++) n_en += int'(en_a[c]);
      cmp++; if (ia_a[4] !== 1'b1 || ird_a[4] !== 32'h0030A5A5) begin mism++; $display("FAIL drop_ack got ack=%b data=%h want 1 0030a5a5", ia_a[4], ird_a[4]); end
      cmp++; if (n_en != 1) begin mism++; $display("FAIL drop_en_count got %0d want 1", n_en); end
   endtask

   task automatic test_back_to_back();
      bit seq[$];
      int n_en = 0;
      if_req = 1; if_addr = 32'h100;
      d_req = 1; d_we = 0; d_addr = 32'h200;
      run(30, -1, 1);
      if_req = 0; d_req = 0;
      for (int c = 0; c < 30; c++) begin
         if (da_a[c]) seq.push_back(1'b1);
         if (ia_a[c]) seq.push_back(1'b0);
         n_en += int'(en_a[c]);
         cmp++; if ((ia_a[c] | da_a[c]) !== (c % 5 == 4)) begin mism++; $display("FAIL b2b_ack_timing cycle %0d got %b%b", c, ia_a[c], da_a[c]); end
      end
      cmp++; if (seq.size() != 6) begin mism++; $display("FAIL b2b_count got %0d want 6", seq.size()); end
      for (int i = 0; i < seq.size() && i < 6; i++) begin
         cmp++; if (seq[i] !== ((i % 2) == 0)) begin mism++; $display("FAIL b2b_order idx %0d got d=%b want d=%b", i, seq[i], (i % 2) == 0); end
      end
      cmp++; if (n_en != 6) begin mism++; $display("FAIL b2b_en_count got %0d want 6", n_en); end
   endtask

   task automatic test_reset_mid();
      int n_ack = 0;
      d_req = 1; d_we = 0; d_addr = 32'h44;
      @(negedge clk); @(negedge clk);
      rst = 0; d_req = 0;
      @(negedge clk); #1;
      cmp++; if ({if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem} !== 6'b0) begin mism++; $display("FAIL rmid_ctrl got %b%b%b%b%b%b want 000000", if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem); end
      cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin mism++; $display("FAIL rmid_data got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata); end
      rst = 1;
      @(negedge clk);
      run(6, -1, 0);
      for (int c = 0; c < 6; c++) n_ack += int'(ia_a[c]) + int'(da_a[c]);
      cmp++; if (n_ack != 0) begin mism++; $display("FAIL rmid_no_ack got %0d want 0", n_ack); end
      if_req = 1; if_addr = 32'h50;
      d_req = 1; d_addr = 32'h60;
      run(12, -1, 0);
      cmp++; if (da_a[4] !== 1'b1 || drd_a[4] !== 32'h0060A5A5) begin mism++; $display("FAIL rmid_d_ack got ack=%b data=%h want 1 0060a5a5", da_a[4], drd_a[4]); end
      cmp++; if (ia_a[9] !== 1'b1 || ird_a[9] !== 32'h0050A5A5) begin mism++; $display("FAIL rmid_if_ack got ack=%b data=%h want 1 0050a5a5", ia_a[9], ird_a[9]); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_both();
      test_store();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 Parameter MEM_LATENCY, default 2, cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 if_req  in  1  fetch request; held with if_addr until if_ack.
REQ-007 if_addr  in  ADDRESS_WIDTH  fetch address.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  out  DATA_WIDTH  fetched instruction; valid while if_ack=1.
REQ-010 d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_ack.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_addr  in  ADDRESS_WIDTH  data address.
REQ-013 d_wdata  in  DATA_WIDTH  store data.
REQ-014 d_ack  out  1  one-cycle data completion pulse.
REQ-015 d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1.
REQ-016 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-017 mem_addr, mem_wdata  out  ADDRESS_WIDTH, DATA_WIDTH  memory address and write data.
REQ-018 mem_rdata  in  DATA_WIDTH  memory read data.
REQ-019 stall_if, stall_mem  out  1 each  pipeline stall requests.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with any request pending, SHALL grant one requester, latch its address, we and wdata, and go to ISSUE.
REQ-022 Grant priority SHALL be data over fetch, except fetch wins when both are pending and the previous grant was data.
REQ-023 ISSUE, one cycle: mem_en=1; mem_addr, mem_we and mem_wdata from the latched values; next state WAIT; latency counter loaded with MEM_LATENCY.
REQ-024 WAIT SHALL decrement the counter each cycle; at count 1, capture mem_rdata into the response register and go to RESP.
REQ-025 RESP, one cycle: assert the granted ack with the registered rdata; next state IDLE; requests SHALL NOT be sampled in RESP.
REQ-026 Request in IDLE at cycle 0 SHALL give mem_en in cycle 1 and ack in cycle MEM_LATENCY+2; throughput is one transaction per MEM_LATENCY+3 cycles.
REQ-027 Stores SHALL follow the same timing and pulse d_ack; d_rdata is don't-care on a store ack.
REQ-028 stall_if SHALL equal if_req & ~if_ack; stall_mem SHALL equal d_req & ~d_ack (combinational).
REQ-029 Outside ISSUE, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
REQ-030 A request dropped before its ack SHALL NOT abort the transaction; the ack still pulses.
REQ-031 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-032 With rst=0 at a clock edge: state IDLE, counter 0, last-grant = fetch, all acks 0, mem_en and mem_we 0, mem_addr, mem_wdata, if_rdata and d_rdata 0.
REQ-033 Reset during ISSUE, WAIT or RESP SHALL abandon the transaction without an ack; the first grant after reset SHALL follow REQ-022 with last-grant = fetch.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (arb_state_t), the grant enum (GNT_IF, GNT_D) and the counter width constant.
REQ-035 The block SHALL be flat with no sub-modules; the latency counter is inline.

Verification (MEM_LATENCY=2; the memory model returns {addr[15:0],16'hA5A5})
REQ-036 if_req with if_addr=0x10 at cycle 0 -> mem_en=1 with mem_addr=0x10 in cycle 1; if_ack=1 with if_rdata=0x0010A5A5 in cycle 4.
REQ-037 if_req (0x20) and d_req load (0x40) both at cycle 0 -> d_ack in cycle 4; fetch issued in cycle 6; if_ack in cycle 9.
REQ-038 Store d_addr=0x80, d_wdata=0xDEADBEEF -> mem_we=1 only in cycle 1; d_ack in cycle 4; stall_mem=1 in cycles 0-3.
REQ-039 Both requests held continuously for 6 transactions -> grants alternate D, IF, D, IF, D, IF.
REQ-040 rst=0 in cycle 2 of a load -> no d_ack; all outputs 0 in the next cycle; a re-asserted request completes normally.
REQ-041 if_req dropped in cycle 2 -> if_ack still pulses in cycle 4; no second mem_en is issued.
